// File: rtl/main_module.sv
// VGA card-table renderer: 640x480@60 timing from a 100 MHz clock, with a
// bordered card whose interior colour comes from a per-frame LFSR.
module main_module #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned CARD_X0     = 240,
  parameter int unsigned CARD_X1     = 399,
  parameter int unsigned CARD_Y0     = 160,
  parameter int unsigned CARD_Y1     = 319,
  parameter int unsigned CARD_BORDER = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        HSync,
  output logic        VSync,
  output logic [15:0] regCard,
  output logic [2:0]  rgb
);

  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] X_OUT0       = 10'(CARD_X0);
  localparam logic [9:0] X_OUT1       = 10'(CARD_X1);
  localparam logic [9:0] Y_OUT0       = 10'(CARD_Y0);
  localparam logic [9:0] Y_OUT1       = 10'(CARD_Y1);
  localparam logic [9:0] X_IN0        = 10'(CARD_X0 + CARD_BORDER);
  localparam logic [9:0] X_IN1        = 10'(CARD_X1 - CARD_BORDER);
  localparam logic [9:0] Y_IN0        = 10'(CARD_Y0 + CARD_BORDER);
  localparam logic [9:0] Y_IN1        = 10'(CARD_Y1 - CARD_BORDER);

  logic [1:0] prescale;
  logic [9:0] h;
  logic [9:0] v;
  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic       lfsr_fb;
  logic       visible;
  logic       in_card;
  logic       in_interior;
  logic       hsync_next;
  logic       vsync_next;
  logic [2:0] rgb_next;

  always_comb begin
    tick        = (prescale == 2'd3);
    h_wrap      = (h == H_LAST);
    v_wrap      = (v == V_LAST);
    lfsr_fb     = regCard[15] ^ regCard[13] ^ regCard[12] ^ regCard[10];
    visible     = (h < H_VIS) && (v < V_VIS);
    in_card     = (h >= X_OUT0) && (h <= X_OUT1) && (v >= Y_OUT0) && (v <= Y_OUT1);
    in_interior = (h >= X_IN0) && (h <= X_IN1) && (v >= Y_IN0) && (v <= Y_IN1);
    hsync_next  = !((h >= H_SYNC_FIRST) && (h <= H_SYNC_LAST));
    vsync_next  = !((v >= V_SYNC_FIRST) && (v <= V_SYNC_LAST));
    rgb_next    = 3'b000;
    if (visible) begin
      if (in_interior)  rgb_next = regCard[2:0];
      else if (in_card) rgb_next = 3'b111;
      else              rgb_next = 3'b010;
    end
  end

  // Outputs are registered from the pre-edge counters, so they trail h/v by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      h        <= '0;
      v        <= '0;
      regCard  <= 16'h0001;
      HSync    <= 1'b1;
      VSync    <= 1'b1;
      rgb      <= '0;
    end else begin
      prescale <= prescale + 2'd1;
      if (tick) begin
        h <= h_wrap ? '0 : h + 10'd1;
        if (h_wrap) begin
          v <= v_wrap ? '0 : v + 10'd1;
          if (v_wrap) regCard <= {regCard[14:0], lfsr_fb};
        end
      end
      HSync <= hsync_next;
      VSync <= vsync_next;
      rgb   <= rgb_next;
    end
  end

endmodule

// File: tb/tb_main_module.sv
// Self-checking bench for main_module on a reduced raster geometry so that
// several frames fit in a short run; expectations come from a closed-form model.
module tb_main_module;

  localparam int unsigned HV = 40, HF = 4, HS = 8, HB = 8;
  localparam int unsigned VV = 24, VF = 2, VS = 2, VB = 4;
  localparam int unsigned HT = HV + HF + HS + HB;     // 60 pixels per line
  localparam int unsigned VT = VV + VF + VS + VB;     // 32 lines per frame
  localparam int unsigned X0 = 10, X1 = 29, Y0 = 6, Y1 = 17, BW = 2;
  localparam int unsigned LINE_CLKS  = HT * 4;
  localparam int unsigned FRAME_CLKS = HT * VT * 4;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic [15:0] card;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        HSync;
  logic        VSync;
  logic [15:0] regCard;
  logic [2:0]  rgb;

  int unsigned n = 0;         // rising edges since the last reset edge
  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        sb_q[$];

  main_module #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CARD_X0(X0), .CARD_X1(X1), .CARD_Y0(Y0), .CARD_Y1(Y1), .CARD_BORDER(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .HSync(HSync),
    .VSync(VSync),
    .regCard(regCard),
    .rgb(rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  function automatic logic [15:0] lfsr_n(input int unsigned frames);
    logic [15:0] q;
    q = 16'h0001;
    for (int unsigned i = 0; i < frames; i++)
      q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    return q;
  endfunction

  // Outputs after edge nn reflect the counters as left by edge nn-1;
  // after edge m, m/4 pixel ticks have happened.
  function automatic exp_t model(input int unsigned nn);
    exp_t        e;
    int unsigned p, x, y;
    logic [15:0] card_prev;
    if (nn == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.rgb = 3'b000; e.card = 16'h0001;
      return e;
    end
    p = (nn - 1) / 4;
    x = p % HT;
    y = (p / HT) % VT;
    card_prev = lfsr_n(p / (HT * VT));
    e.card = lfsr_n((nn / 4) / (HT * VT));
    e.hs   = !(x >= HV + HF && x < HV + HF + HS);
    e.vs   = !(y >= VV + VF && y < VV + VF + VS);
    if (x >= HV || y >= VV)                                         e.rgb = 3'b000;
    else if (x >= X0 + BW && x <= X1 - BW && y >= Y0 + BW && y <= Y1 - BW) e.rgb = card_prev[2:0];
    else if (x >= X0 && x <= X1 && y >= Y0 && y <= Y1)               e.rgb = 3'b111;
    else                                                            e.rgb = 3'b010;
    return e;
  endfunction

  function automatic int unsigned pix_n(input int unsigned f, input int unsigned x,
                                        input int unsigned y);
    return 4 * (f * HT * VT + y * HT + x) + 2;
  endfunction

  // Leaves the bench at the falling clk edge right after the reset edge (n == 0).
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_until(input int unsigned target);
    int unsigned guard;
    guard = 0;
    while (n < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic find_edge(input bit use_v, input logic want, input int unsigned bound,
                           output int unsigned at, output bit found);
    logic prev, cur;
    prev  = use_v ? VSync : HSync;
    found = 1'b0;
    at    = 0;
    for (int unsigned i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      cur = use_v ? VSync : HSync;
      if (prev !== want && cur === want) begin
        found = 1'b1;
        at    = n;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests += 4;
    if (HSync !== 1'b1)       begin fails++; $display("FAIL reset_hsync: got %b expected 1", HSync); end
    if (VSync !== 1'b1)       begin fails++; $display("FAIL reset_vsync: got %b expected 1", VSync); end
    if (rgb !== 3'b000)       begin fails++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
    if (regCard !== 16'h0001) begin fails++; $display("FAIL reset_card: got %h expected 0001", regCard); end
    @(negedge clk);
    tests += 2;
    if (rgb !== 3'b010)       begin fails++; $display("FAIL first_pixel_rgb: got %b expected 010", rgb); end
    if (HSync !== 1'b1)       begin fails++; $display("FAIL first_pixel_hsync: got %b expected 1", HSync); end
  endtask

  task automatic test_line_timing();
    int unsigned fall0, rise0, fall1;
    bit          ok;
    find_edge(1'b0, 1'b0, 2 * LINE_CLKS, fall0, ok);
    tests++;
    if (!ok || fall0 !== (HV + HF) * 4 + 1) begin
      fails++; $display("FAIL hsync_first_fall: got n=%0d (found=%0d) expected %0d", fall0, ok, (HV + HF) * 4 + 1);
    end
    find_edge(1'b0, 1'b1, 2 * LINE_CLKS, rise0, ok);
    tests++;
    if (!ok || rise0 - fall0 !== HS * 4) begin
      fails++; $display("FAIL hsync_low_width: got %0d (found=%0d) expected %0d", rise0 - fall0, ok, HS * 4);
    end
    find_edge(1'b0, 1'b0, 2 * LINE_CLKS, fall1, ok);
    tests++;
    if (!ok || fall1 - fall0 !== LINE_CLKS) begin
      fails++; $display("FAIL hsync_period: got %0d (found=%0d) expected %0d", fall1 - fall0, ok, LINE_CLKS);
    end
  endtask

  task automatic test_frame_timing();
    int unsigned fall0, rise0, fall1;
    bit          ok;
    find_edge(1'b1, 1'b0, 2 * FRAME_CLKS, fall0, ok);
    tests++;
    if (!ok || fall0 !== (VV + VF) * LINE_CLKS + 1) begin
      fails++; $display("FAIL vsync_first_fall: got n=%0d (found=%0d) expected %0d", fall0, ok, (VV + VF) * LINE_CLKS + 1);
    end
    find_edge(1'b1, 1'b1, 2 * FRAME_CLKS, rise0, ok);
    tests++;
    if (!ok || rise0 - fall0 !== VS * LINE_CLKS) begin
      fails++; $display("FAIL vsync_low_width: got %0d (found=%0d) expected %0d", rise0 - fall0, ok, VS * LINE_CLKS);
    end
    find_edge(1'b1, 1'b0, 2 * FRAME_CLKS, fall1, ok);
    tests++;
    if (!ok || fall1 - fall0 !== FRAME_CLKS) begin
      fails++; $display("FAIL vsync_period: got %0d (found=%0d) expected %0d", fall1 - fall0, ok, FRAME_CLKS);
    end
  endtask

  // Every output compared every clk across frame 0 and into frame 1.
  task automatic test_scoreboard();
    exp_t e, got;
    apply_reset();
    for (int unsigned i = 0; i < FRAME_CLKS + 20; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(model(n));
      @(negedge clk);
      e   = sb_q.pop_front();
      got = {HSync, VSync, rgb, regCard};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL scoreboard n=%0d: got hs=%b vs=%b rgb=%b card=%h expected hs=%b vs=%b rgb=%b card=%h",
                 n, got.hs, got.vs, got.rgb, got.card, e.hs, e.vs, e.rgb, e.card);
      end
    end
  endtask

  task automatic test_pixel_map();
    int unsigned px[6]   = '{5, 50, 10, 15, 28, 15};
    int unsigned py[6]   = '{5, 5, 10, 12, 16, 28};
    logic [2:0]  want[6] = '{3'b010, 3'b000, 3'b111, 3'b010, 3'b111, 3'b000};
    for (int unsigned i = 0; i < 6; i++) begin
      wait_until(pix_n(1, px[i], py[i]));
      tests++;
      if (rgb !== want[i]) begin
        fails++; $display("FAIL pixel(%0d,%0d): got %b expected %b", px[i], py[i], rgb, want[i]);
      end
    end
  endtask

  task automatic test_lfsr();
    wait_until(2 * FRAME_CLKS - 1);
    tests++;
    if (regCard !== 16'h0002) begin fails++; $display("FAIL card_end_frame1: got %h expected 0002", regCard); end
    @(negedge clk);
    tests++;
    if (regCard !== 16'h0004) begin fails++; $display("FAIL card_frame2: got %h expected 0004", regCard); end
    wait_until(pix_n(2, 15, 12));
    tests++;
    if (rgb !== 3'b100) begin fails++; $display("FAIL interior_frame2: got %b expected 100", rgb); end
    wait_until(3 * FRAME_CLKS - 1);
    tests++;
    if (regCard !== 16'h0004) begin fails++; $display("FAIL card_end_frame2: got %h expected 0004", regCard); end
    @(negedge clk);
    tests++;
    if (regCard !== 16'h0008) begin fails++; $display("FAIL card_frame3: got %h expected 0008", regCard); end
  endtask

  task automatic test_mid_reset();
    int unsigned fall;
    bit          ok;
    wait_until(pix_n(3, 20, 12));
    tests++;
    if (rgb !== 3'b000) begin fails++; $display("FAIL interior_frame3: got %b expected 000", rgb); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests += 4;
    if (HSync !== 1'b1)       begin fails++; $display("FAIL mid_reset_hsync: got %b expected 1", HSync); end
    if (VSync !== 1'b1)       begin fails++; $display("FAIL mid_reset_vsync: got %b expected 1", VSync); end
    if (rgb !== 3'b000)       begin fails++; $display("FAIL mid_reset_rgb: got %b expected 000", rgb); end
    if (regCard !== 16'h0001) begin fails++; $display("FAIL mid_reset_card: got %h expected 0001", regCard); end
    @(negedge clk);
    tests++;
    if (rgb !== 3'b010) begin fails++; $display("FAIL mid_reset_first_pixel: got %b expected 010", rgb); end
    find_edge(1'b0, 1'b0, 2 * LINE_CLKS, fall, ok);
    tests++;
    if (!ok || fall !== (HV + HF) * 4 + 1) begin
      fails++; $display("FAIL mid_reset_hsync_fall: got n=%0d (found=%0d) expected %0d", fall, ok, (HV + HF) * 4 + 1);
    end
    tests++;
    if (regCard !== 16'h0001) begin fails++; $display("FAIL mid_reset_card_hold: got %h expected 0001", regCard); end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_scoreboard();
    test_pixel_map();
    test_lfsr();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
